// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared types and constants for the note sequencer.
//   seq_state_t  playback state (IDLE / GATE_ON / GATE_OFF)
//   step_t       pattern RAM entry {rest, freq_bin[3:0]}
//   REST_ENTRY   reset value of every pattern entry
//   LFSR_*       random step-order generator (used only with NOTE_SEQ_RANDOM_EN)
package note_seq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_ON  = 2'd1,
        GATE_OFF = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic       rest;
        logic [3:0] freq_bin;
    } step_t;

    localparam step_t REST_ENTRY = '{rest: 1'b1, freq_bin: 4'h0};

    // x^8 + x^6 + x^5 + x^4 + 1, shifting left: feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
    localparam logic [7:0] LFSR_SEED = 8'h01;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/seq_tick_div.sv
// seq_tick_div: free-running clock divider producing the sample-rate strobe.
//   clk, rst_n   clock, asynchronous active-low reset
//   sample_tick  1-clk pulse on the cycle the count equals CLK_DIV-1
module seq_tick_div #(
    parameter int unsigned CLK_DIV = 1134
) (
    input  logic clk,
    input  logic rst_n,
    output logic sample_tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign sample_tick = (cnt_q == LAST);

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: 16-step programmable note sequencer feeding soundproc.
//   clk, rst_n      clock, asynchronous active-low reset
//   run             1 = play, 0 = stop (gate off, back to step 0)
//   wr_en/addr/data pattern RAM write port, data = {rest, freq_bin}
//   seq_len         index of the last step played before wrapping
//   tempo           step length = (tempo+1)*TEMPO_UNIT sample ticks
//   gate_len        gate duty (gate_len+1)/4 of a step
//   rand_mode       random step order (NOTE_SEQ_RANDOM_EN builds only)
//   sample_tick     sample-rate strobe, every CLK_DIV clocks
//   tone_freq_bin   current note, gate note-on level
//   step_idx        step playing, step_strobe 1-clk pulse on each step load
// Optional feature macro: NOTE_SEQ_RANDOM_EN (LFSR random step order).
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 1134,
    parameter int unsigned TEMPO_UNIT = 512,
    parameter int unsigned STEPS      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic [3:0] seq_len,
    input  logic [3:0] tempo,
    input  logic [1:0] gate_len,
    input  logic       rand_mode,
    output logic       sample_tick,
    output logic [3:0] tone_freq_bin,
    output logic       gate,
    output logic [3:0] step_idx,
    output logic       step_strobe
);

    seq_state_t  state_q, state_d;
    logic [13:0] tick_q, tick_d;
    logic [3:0]  step_idx_q, step_idx_d;
    logic [3:0]  tone_q, tone_d;
    logic        gate_q, gate_d;
    logic        strobe_q, strobe_d;
    step_t       ram_q [STEPS];
    step_t       ram_d [STEPS];

    logic [31:0] step_ticks, gate_ticks;
    logic [3:0]  next_addr, load_addr;
    logic        load;
    step_t       entry;

    seq_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick)
    );

`ifdef NOTE_SEQ_RANDOM_EN
    logic [7:0] lfsr_q, lfsr_d;
`else
    logic unused_rand_mode;
    assign unused_rand_mode = rand_mode;
`endif

    always_comb begin
        step_ticks = (32'(tempo) + 32'd1) * TEMPO_UNIT;
        gate_ticks = (step_ticks >> 2) * (32'(gate_len) + 32'd1);
        // full duty still leaves one low tick so the envelope retriggers
        if (gate_len == 2'd3) gate_ticks = gate_ticks - 32'd1;
    end

    always_comb begin
        next_addr = (step_idx_q >= seq_len) ? 4'd0 : step_idx_q + 4'd1;
`ifdef NOTE_SEQ_RANDOM_EN
        if (rand_mode) next_addr = (lfsr_q[3:0] <= seq_len) ? lfsr_q[3:0] : 4'd0;
`endif
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        step_idx_d = step_idx_q;
        tone_d     = tone_q;
        gate_d     = gate_q;
        strobe_d   = 1'b0;
        load       = 1'b0;
        load_addr  = 4'd0;
        ram_d      = ram_q;
`ifdef NOTE_SEQ_RANDOM_EN
        lfsr_d     = lfsr_q;
`endif
        if (wr_en) ram_d[wr_addr] = step_t'(wr_data);

        if (!run) begin
            state_d    = IDLE;
            gate_d     = 1'b0;
            step_idx_d = 4'd0;
        end else if (sample_tick) begin
            case (state_q)
                IDLE: begin
                    load      = 1'b1;
                    load_addr = 4'd0;
                end
                GATE_ON, GATE_OFF: begin
                    // >= rather than == so a mid-step tempo/gate shrink cannot overrun
                    if (32'(tick_q) >= step_ticks - 32'd1) begin
                        load      = 1'b1;
                        load_addr = next_addr;
                    end else begin
                        tick_d = tick_q + 14'd1;
                        if (state_q == GATE_ON && 32'(tick_q) + 32'd1 >= gate_ticks) begin
                            state_d = GATE_OFF;
                            gate_d  = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // ram_q (not ram_d) so a same-cycle write to this step is not seen
        entry = ram_q[load_addr];
        if (load) begin
            strobe_d   = 1'b1;
            step_idx_d = load_addr;
            tick_d     = '0;
            if (entry.rest) begin
                gate_d  = 1'b0;
                state_d = GATE_OFF;
            end else begin
                tone_d  = entry.freq_bin;
                gate_d  = 1'b1;
                state_d = GATE_ON;
            end
`ifdef NOTE_SEQ_RANDOM_EN
            lfsr_d = lfsr_next(lfsr_q);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            step_idx_q <= '0;
            tone_q     <= '0;
            gate_q     <= 1'b0;
            strobe_q   <= 1'b0;
            for (int unsigned i = 0; i < STEPS; i++) ram_q[i] <= REST_ENTRY;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            step_idx_q <= step_idx_d;
            tone_q     <= tone_d;
            gate_q     <= gate_d;
            strobe_q   <= strobe_d;
            ram_q      <= ram_d;
        end
    end

`ifdef NOTE_SEQ_RANDOM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end
`endif

    assign tone_freq_bin = tone_q;
    assign gate          = gate_q;
    assign step_idx      = step_idx_q;
    assign step_strobe   = strobe_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: scoreboard bench for note_sequencer (CLK_DIV=4, TEMPO_UNIT=4).
// Expected steps {idx, tone, gate, gate-high ticks} are queued as stimulus is
// applied; a monitor pops one per step_strobe.
module tb_note_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [4:0] wr_data = '0;
    logic [3:0] seq_len = '0;
    logic [3:0] tempo = '0;
    logic [1:0] gate_len = '0;
    logic       rand_mode = 1'b0;
    logic       sample_tick;
    logic [3:0] tone_freq_bin;
    logic       gate;
    logic [3:0] step_idx;
    logic       step_strobe;

    always #5 clk = ~clk;

    note_sequencer #(.CLK_DIV(4), .TEMPO_UNIT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .seq_len       (seq_len),
        .tempo         (tempo),
        .gate_len      (gate_len),
        .rand_mode     (rand_mode),
        .sample_tick   (sample_tick),
        .tone_freq_bin (tone_freq_bin),
        .gate          (gate),
        .step_idx      (step_idx),
        .step_strobe   (step_strobe)
    );

    typedef struct {
        logic [3:0] idx;
        logic [3:0] tone;
        logic       gate;
        int         hi;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b1;
    int   cfg_epoch = 0;
    int   mon_epoch = 0;
    bit   hi_armed = 1'b0;
    int   hi_cnt = 0;
    int   cur_hi = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] idx, input logic [3:0] tone, input logic g, input int hi);
        exp_t e;
        e.idx = idx; e.tone = tone; e.gate = g; e.hi = hi;
        exp_q.push_back(e);
    endtask

    task automatic write_step(input logic [3:0] a, input logic [4:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    task monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (step_strobe) begin
                    if (hi_armed && mon_epoch == cfg_epoch) check("gate_hi_ticks", hi_cnt, cur_hi);
                    check("strobe_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("step_idx", step_idx, e.idx);
                        check("tone", tone_freq_bin, e.tone);
                        check("gate_at_load", gate, e.gate);
                        cur_hi = e.hi;
                        hi_armed = 1'b1;
                    end else begin
                        hi_armed = 1'b0;
                    end
                    mon_epoch = cfg_epoch;
                    hi_cnt = 0;
                end else if (sample_tick && gate) begin
                    hi_cnt++;
                end
            end else begin
                hi_armed = 1'b0;
            end
        end
    endtask

    initial begin
        int ticks, ghi, strobes, cyc;
        fork monitor_loop(); join_none

        // 1. reset values, idle divider
        #23;
        check("rst_step_idx", step_idx, 0);
        check("rst_tone", tone_freq_bin, 0);
        check("rst_gate", gate, 0);
        check("rst_strobe", step_strobe, 0);
        check("rst_tick", sample_tick, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        ticks = 0; ghi = 0; strobes = 0;
        repeat (40) begin
            @(negedge clk);
            ticks += int'(sample_tick);
            ghi += int'(gate);
            strobes += int'(step_strobe);
        end
        check("idle_tick_count", ticks, 10);
        check("idle_gate", ghi, 0);
        check("idle_strobes", strobes, 0);

        // 2. 5, 9, rest; wrap after step 2
        write_step(4'd0, 5'd5);
        write_step(4'd1, 5'd9);
        write_step(4'd2, 5'b1_0000);
        @(posedge clk); #1;
        seq_len = 4'd2; tempo = 4'd0; gate_len = 2'd1;
        push(0, 5, 1, 2); push(1, 9, 1, 2); push(2, 9, 0, 0);
        push(0, 5, 1, 2); push(1, 9, 1, 2); push(2, 9, 0, 0);
        push(0, 5, 1, 2);
        run = 1'b1;
        wait_drain();

        // 3. full duty: 3 high, 1 low
        gate_len = 2'd3; cfg_epoch++;
        push(1, 9, 1, 3); push(2, 9, 0, 0); push(0, 5, 1, 3); push(1, 9, 1, 3);
        wait_drain();

        // 4. edit the playing step
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 5'd12;
        @(posedge clk); #1; wr_en = 1'b0;
        repeat (3) @(negedge clk);
        check("edit_no_glitch", tone_freq_bin, 9);
        push(2, 9, 0, 0); push(0, 5, 1, 3); push(1, 12, 1, 3); push(2, 12, 0, 0);
        wait_drain();

        // 5. stop during GATE_ON, then restart
        push(0, 5, 1, 3);
        wait_drain();
        repeat (6) @(posedge clk); #1;
        check("gate_on_before_stop", gate, 1);
        run = 1'b0; cfg_epoch++;
        @(posedge clk); #1;
        check("stop_gate", gate, 0);
        check("stop_idx", step_idx, 0);
        check("stop_tone_held", tone_freq_bin, 5);
        repeat (40) @(posedge clk); #1;
        push(0, 5, 1, 3); push(1, 12, 1, 3);
        run = 1'b1;
        cyc = 0;
        while (exp_q.size() > 1 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        check("restart_latency", cyc <= 6, 1);
        wait_drain();

        // 6. seq_len shrinks below the playing step
        seq_len = 4'd7;
        push(2, 12, 0, 0); push(3, 12, 0, 0); push(4, 12, 0, 0); push(5, 12, 0, 0);
        wait_drain();
        check("at_step5", step_idx, 5);
        seq_len = 4'd1;
        push(0, 5, 1, 3); push(1, 12, 1, 3); push(0, 5, 1, 3);
        wait_drain();

`ifdef NOTE_SEQ_RANDOM_EN
        mon_en = 1'b0; cfg_epoch++;
        seq_len = 4'd5; rand_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!step_strobe && cyc < 200);
            check("rand_bound", step_idx <= seq_len, 1);
        end
        rand_mode = 1'b0;
        seq_len = 4'd1;
        @(posedge clk); #1;
        mon_en = 1'b1;
`endif

        // reset mid-step: outputs clear at once, pattern reverts to rests
        mon_en = 1'b0;
        repeat (5) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_idx", step_idx, 0);
        check("midrst_gate", gate, 0);
        check("midrst_tone", tone_freq_bin, 0);
        exp_q.delete();
        cfg_epoch++;
        repeat (3) @(posedge clk); #1;
        mon_en = 1'b1;
        push(0, 0, 0, 0); push(1, 0, 0, 0);
        rst_n = 1'b1;
        wait_drain();
        run = 1'b0;
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
